decode_stage: RTL and testbench

Instruction-decode stage of the five-stage MIPS pipeline, placed directly downstream of the fetch stage's IF/ID register. It decodes the IF/ID instruction, reads and writes the 32×32 register file, and resolves branches and jumps in ID. It detects load-use and branch-operand hazards, drives the fetch-stage control inputs (PC write, IF/ID write, flush, branch/jump select and targets), and owns the ID/EX pipeline register.

---
 rtl/decode_stage.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// MIPS ID stage: decode, register file, ID-resolved branches/jumps, hazards, ID/EX register.
// Optional ID_BRANCH_FWD_EN: EX/MEM ALU result forwarding into the branch comparator.
`ifndef NB_BITS
`define NB_BITS 32
`endif

module decode_stage #(
  parameter int NB_BITS = `NB_BITS,
  parameter int NB_REG  = 5,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BITS-1:0] i_if_id_pc,
  input  logic [NB_BITS-1:0] i_if_id_instr,
  input  logic               i_wb_we,
  input  logic [NB_REG-1:0]  i_wb_rd,
  input  logic [NB_BITS-1:0] i_wb_data,
  input  logic               i_ex_mem_reg_write,
  input  logic               i_ex_mem_mem_read,
  input  logic [NB_REG-1:0]  i_ex_mem_rd,
  input  logic [NB_BITS-1:0] i_ex_mem_data,
  output logic [NB_BITS-1:0] o_brq_addr,
  output logic [NB_BITS-1:0] o_jmp_addr,
  output logic               o_ctr_beq,
  output logic               o_ctr_jmp,
  output logic               o_ctr_flush,
  output logic               o_pc_we,
  output logic               o_if_id_we,
  output logic [NB_BITS-1:0] o_id_ex_pc,
  output logic [NB_BITS-1:0] o_id_ex_rs_data,
  output logic [NB_BITS-1:0] o_id_ex_rt_data,
  output logic [NB_BITS-1:0] o_id_ex_imm,
  output logic [NB_REG-1:0]  o_id_ex_rs,
  output logic [NB_REG-1:0]  o_id_ex_rt,
  output logic [NB_REG-1:0]  o_id_ex_dst,
  output logic [NB_REG-1:0]  o_id_ex_shamt,
  output logic [NB_OP-1:0]   o_id_ex_op,
  output logic [NB_OP-1:0]   o_id_ex_funct,
  output logic               o_id_ex_alu_src,
  output logic               o_id_ex_mem_read,
  output logic               o_id_ex_mem_write,
  output logic               o_id_ex_mem_to_reg,
  output logic               o_id_ex_reg_write
);

  localparam logic [NB_OP-1:0] OP_R    = 6'h00;
  localparam logic [NB_OP-1:0] OP_J    = 6'h02;
  localparam logic [NB_OP-1:0] OP_BEQ  = 6'h04;
  localparam logic [NB_OP-1:0] OP_BNE  = 6'h05;
  localparam logic [NB_OP-1:0] OP_ADDI = 6'h08;
  localparam logic [NB_OP-1:0] OP_SLTI = 6'h0A;
  localparam logic [NB_OP-1:0] OP_ANDI = 6'h0C;
  localparam logic [NB_OP-1:0] OP_ORI  = 6'h0D;
  localparam logic [NB_OP-1:0] OP_XORI = 6'h0E;
  localparam logic [NB_OP-1:0] OP_LUI  = 6'h0F;
  localparam logic [NB_OP-1:0] OP_LW   = 6'h23;
  localparam logic [NB_OP-1:0] OP_SW   = 6'h2B;
  localparam logic [NB_OP-1:0] FN_JR   = 6'h08;

  typedef struct packed {
    logic [NB_BITS-1:0] pc;
    logic [NB_BITS-1:0] rs_data;
    logic [NB_BITS-1:0] rt_data;
    logic [NB_BITS-1:0] imm;
    logic [NB_REG-1:0]  rs;
    logic [NB_REG-1:0]  rt;
    logic [NB_REG-1:0]  dst;
    logic [NB_REG-1:0]  shamt;
    logic [NB_OP-1:0]   op;
    logic [NB_OP-1:0]   funct;
    logic               alu_src;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
  } id_ex_t;

  logic [NB_OP-1:0]  op;
  logic [NB_OP-1:0]  funct;
  logic [NB_REG-1:0] rs;
  logic [NB_REG-1:0] rt;
  logic [NB_REG-1:0] rd;
  logic [NB_REG-1:0] shamt;

  assign op    = i_if_id_instr[31:26];
  assign rs    = i_if_id_instr[25:21];
  assign rt    = i_if_id_instr[20:16];
  assign rd    = i_if_id_instr[15:11];
  assign shamt = i_if_id_instr[10:6];
  assign funct = i_if_id_instr[5:0];

  logic [NB_BITS-1:0] rf [2**NB_REG];
  logic [NB_BITS-1:0] rs_val;
  logic [NB_BITS-1:0] rt_val;
  logic [NB_BITS-1:0] br_rs;
  logic [NB_BITS-1:0] br_rt;
  logic [NB_BITS-1:0] imm;
  id_ex_t             id_ex_q;
  id_ex_t             id_ex_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 2**NB_REG; i++)
        rf[i] <= '0;
    end else if (i_wb_we && i_wb_rd != '0) begin
      rf[i_wb_rd] <= i_wb_data;
    end
  end

  // write-first: a same-cycle writeback is visible to this read
  always_comb begin
    rs_val = rf[rs];
    rt_val = rf[rt];
    if (i_wb_we && i_wb_rd == rs) rs_val = i_wb_data;
    if (i_wb_we && i_wb_rd == rt) rt_val = i_wb_data;
    if (rs == '0) rs_val = '0;
    if (rt == '0) rt_val = '0;
  end

`ifdef ID_BRANCH_FWD_EN
  logic fwd_ok;
  assign fwd_ok = i_ex_mem_reg_write &&
                  !i_ex_mem_mem_read &&
                  i_ex_mem_rd != '0;
  assign br_rs = (fwd_ok && i_ex_mem_rd == rs) ?
                 i_ex_mem_data : rs_val;
  assign br_rt = (fwd_ok && i_ex_mem_rd == rt) ?
                 i_ex_mem_data : rt_val;
`else
  logic unused_ex_mem_data;
  assign unused_ex_mem_data = ^i_ex_mem_data;
  assign br_rs = rs_val;
  assign br_rt = rt_val;
`endif

  logic is_r, is_j, is_beq, is_bne, is_alui;
  logic is_lw, is_sw, is_zext;
  logic is_jr;
  logic c_alu_src, c_mem_read, c_mem_write;
  logic c_mem_to_reg, c_reg_write;
  logic [NB_REG-1:0] c_dst;

  assign is_r    = op == OP_R;
  assign is_j    = op == OP_J;
  assign is_beq  = op == OP_BEQ;
  assign is_bne  = op == OP_BNE;
  assign is_lw   = op == OP_LW;
  assign is_sw   = op == OP_SW;
  assign is_zext = op == OP_ANDI || op == OP_ORI ||
                   op == OP_XORI;
  assign is_alui = is_zext || op == OP_ADDI ||
                   op == OP_SLTI || op == OP_LUI;
  assign is_jr   = is_r && funct == FN_JR;

  assign imm = is_zext ?
    {{(NB_BITS-16){1'b0}}, i_if_id_instr[15:0]} :
    {{(NB_BITS-16){i_if_id_instr[15]}},
     i_if_id_instr[15:0]};

  always_comb begin
    c_alu_src    = 1'b0;
    c_mem_read   = 1'b0;
    c_mem_write  = 1'b0;
    c_mem_to_reg = 1'b0;
    c_reg_write  = 1'b0;
    c_dst        = rt;
    unique case (1'b1)
      is_r: begin
        c_dst = rd;
        // all-zero word is the flush NOP, kept as a bubble
        c_reg_write = !is_jr && i_if_id_instr != '0;
      end
      is_alui: begin
        c_alu_src   = 1'b1;
        c_reg_write = 1'b1;
      end
      is_lw: begin
        c_alu_src    = 1'b1;
        c_mem_read   = 1'b1;
        c_mem_to_reg = 1'b1;
        c_reg_write  = 1'b1;
      end
      is_sw: begin
        c_alu_src   = 1'b1;
        c_mem_write = 1'b1;
      end
      default: ;
    endcase
  end

  function automatic logic br_hit(
    input logic [NB_REG-1:0] src
  );
    logic hit;
    hit = (id_ex_q.reg_write && id_ex_q.dst == src) ||
          (i_ex_mem_mem_read && i_ex_mem_rd == src);
`ifndef ID_BRANCH_FWD_EN
    hit = hit ||
          (i_ex_mem_reg_write && i_ex_mem_rd == src);
`endif
    return hit && src != '0;
  endfunction

  logic load_use, br_stall, stall;
  logic take_br;

  assign load_use = id_ex_q.mem_read &&
                    id_ex_q.rt != '0 &&
                    (id_ex_q.rt == rs || id_ex_q.rt == rt);
  assign br_stall = ((is_beq || is_bne || is_jr) && br_hit(rs)) ||
                    ((is_beq || is_bne) && br_hit(rt));
  assign stall    = load_use || br_stall;

  assign take_br = (is_beq && br_rs == br_rt) ||
                   (is_bne && br_rs != br_rt);

  always_comb begin
    o_pc_we    = !stall;
    o_if_id_we = !stall;
    o_ctr_beq  = 1'b0;
    o_ctr_jmp  = 1'b0;
    o_brq_addr = '0;
    o_jmp_addr = '0;
    if (!stall) begin
      unique case (1'b1)
        take_br: begin
          o_ctr_beq  = 1'b1;
          o_brq_addr = i_if_id_pc + (imm << 2);
        end
        is_j: begin
          o_ctr_jmp  = 1'b1;
          o_jmp_addr = {i_if_id_pc[NB_BITS-1:NB_BITS-4],
                        i_if_id_instr[25:0], 2'b00};
        end
        is_jr: begin
          o_ctr_jmp  = 1'b1;
          o_jmp_addr = br_rs;
        end
        default: ;
      endcase
    end
    o_ctr_flush = o_ctr_beq || o_ctr_jmp;
  end

  always_comb begin
    id_ex_d            = '0;
    id_ex_d.pc         = i_if_id_pc;
    id_ex_d.rs_data    = rs_val;
    id_ex_d.rt_data    = rt_val;
    id_ex_d.imm        = imm;
    id_ex_d.rs         = rs;
    id_ex_d.rt         = rt;
    id_ex_d.dst        = c_dst;
    id_ex_d.shamt      = shamt;
    id_ex_d.op         = op;
    id_ex_d.funct      = funct;
    id_ex_d.alu_src    = c_alu_src;
    id_ex_d.mem_read   = c_mem_read;
    id_ex_d.mem_write  = c_mem_write;
    id_ex_d.mem_to_reg = c_mem_to_reg;
    id_ex_d.reg_write  = c_reg_write;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || stall)
      id_ex_q <= '0;
    else
      id_ex_q <= id_ex_d;
  end

  assign o_id_ex_pc         = id_ex_q.pc;
  assign o_id_ex_rs_data    = id_ex_q.rs_data;
  assign o_id_ex_rt_data    = id_ex_q.rt_data;
  assign o_id_ex_imm        = id_ex_q.imm;
  assign o_id_ex_rs         = id_ex_q.rs;
  assign o_id_ex_rt         = id_ex_q.rt;
  assign o_id_ex_dst        = id_ex_q.dst;
  assign o_id_ex_shamt      = id_ex_q.shamt;
  assign o_id_ex_op         = id_ex_q.op;
  assign o_id_ex_funct      = id_ex_q.funct;
  assign o_id_ex_alu_src    = id_ex_q.alu_src;
  assign o_id_ex_mem_read   = id_ex_q.mem_read;
  assign o_id_ex_mem_write  = id_ex_q.mem_write;
  assign o_id_ex_mem_to_reg = id_ex_q.mem_to_reg;
  assign o_id_ex_reg_write  = id_ex_q.reg_write;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected ID/EX bundles queued at issue,
// popped one cycle later; fetch controls checked combinationally.
`timescale 1ns/1ps

module tb_decode_stage;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_if_id_pc;
  logic [31:0] i_if_id_instr;
  logic        i_wb_we;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic        i_ex_mem_reg_write;
  logic        i_ex_mem_mem_read;
  logic [4:0]  i_ex_mem_rd;
  logic [31:0] i_ex_mem_data;
  logic [31:0] o_brq_addr, o_jmp_addr;
  logic        o_ctr_beq, o_ctr_jmp, o_ctr_flush;
  logic        o_pc_we, o_if_id_we;
  logic [31:0] o_id_ex_pc, o_id_ex_rs_data;
  logic [31:0] o_id_ex_rt_data, o_id_ex_imm;
  logic [4:0]  o_id_ex_rs, o_id_ex_rt;
  logic [4:0]  o_id_ex_dst, o_id_ex_shamt;
  logic [5:0]  o_id_ex_op, o_id_ex_funct;
  logic        o_id_ex_alu_src, o_id_ex_mem_read;
  logic        o_id_ex_mem_write, o_id_ex_mem_to_reg;
  logic        o_id_ex_reg_write;

  decode_stage dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_id_pc(i_if_id_pc),
    .i_if_id_instr(i_if_id_instr),
    .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd),
    .i_wb_data(i_wb_data),
    .i_ex_mem_reg_write(i_ex_mem_reg_write),
    .i_ex_mem_mem_read(i_ex_mem_mem_read),
    .i_ex_mem_rd(i_ex_mem_rd),
    .i_ex_mem_data(i_ex_mem_data),
    .o_brq_addr(o_brq_addr), .o_jmp_addr(o_jmp_addr),
    .o_ctr_beq(o_ctr_beq), .o_ctr_jmp(o_ctr_jmp),
    .o_ctr_flush(o_ctr_flush), .o_pc_we(o_pc_we),
    .o_if_id_we(o_if_id_we),
    .o_id_ex_pc(o_id_ex_pc),
    .o_id_ex_rs_data(o_id_ex_rs_data),
    .o_id_ex_rt_data(o_id_ex_rt_data),
    .o_id_ex_imm(o_id_ex_imm),
    .o_id_ex_rs(o_id_ex_rs), .o_id_ex_rt(o_id_ex_rt),
    .o_id_ex_dst(o_id_ex_dst),
    .o_id_ex_shamt(o_id_ex_shamt),
    .o_id_ex_op(o_id_ex_op),
    .o_id_ex_funct(o_id_ex_funct),
    .o_id_ex_alu_src(o_id_ex_alu_src),
    .o_id_ex_mem_read(o_id_ex_mem_read),
    .o_id_ex_mem_write(o_id_ex_mem_write),
    .o_id_ex_mem_to_reg(o_id_ex_mem_to_reg),
    .o_id_ex_reg_write(o_id_ex_reg_write)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  logic [41:0] sb [$];
  logic [41:0] e;

  // {dst, imm, alu_src, mem_read, mem_write, mem_to_reg, reg_write}
  function automatic logic [41:0] ex(
    input logic [4:0] d, input logic [31:0] im,
    input logic [4:0] c);
    return {d, im, c};
  endfunction

  function automatic logic [41:0] idex();
    return {o_id_ex_dst, o_id_ex_imm, o_id_ex_alu_src,
            o_id_ex_mem_read, o_id_ex_mem_write,
            o_id_ex_mem_to_reg, o_id_ex_reg_write};
  endfunction

  // {pc_we, if_id_we, beq, jmp, flush}
  function automatic logic [4:0] fc();
    return {o_pc_we, o_if_id_we, o_ctr_beq,
            o_ctr_jmp, o_ctr_flush};
  endfunction

  function automatic logic [31:0] itype(
    input logic [5:0] op, input logic [4:0] s,
    input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  function automatic logic [31:0] rtype(
    input logic [4:0] s, input logic [4:0] t,
    input logic [4:0] d, input logic [5:0] fn);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins,
                       input logic [31:0] pc);
    i_if_id_instr = ins;
    i_if_id_pc    = pc;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    issue(32'h2001_0005, 32'h4);
    tick();
    tick();
    checks++;
    if (idex() !== 42'd0) begin
      errors++;
      $display("FAIL reset_idex got %h want 0", idex());
    end
    checks++;
    if ({o_id_ex_pc, o_id_ex_rs_data} !== 64'd0) begin
      errors++;
      $display("FAIL reset_data got %h %h want 0",
               o_id_ex_pc, o_id_ex_rs_data);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_regfile();
    issue(itype(6'h08, 5'd0, 5'd1, 16'd5), 32'h4);
    sb.push_back(ex(5'd1, 32'd5, 5'b10001));
    #1;
    checks++;
    if (fc() !== 5'b11000) begin
      errors++;
      $display("FAIL addi_ctl got %b want 11000", fc());
    end
    tick();
    e = sb.pop_front();
    checks++;
    if (idex() !== e) begin
      errors++;
      $display("FAIL addi_idex got %h want %h", idex(), e);
    end
    issue(32'h0, 32'h8);
    sb.push_back(ex(5'd0, 32'd0, 5'b00000));
    tick();
    e = sb.pop_front();
    checks++;
    if (idex() !== e) begin
      errors++;
      $display("FAIL nop_idex got %h want %h", idex(), e);
    end
    i_wb_we = 1'b1; i_wb_rd = 5'd1; i_wb_data = 32'd5;
    issue(rtype(5'd1, 5'd0, 5'd6, 6'h20), 32'hC);
    sb.push_back(ex(5'd6, 32'h3020, 5'b00001));
    tick();
    e = sb.pop_front();
    checks++;
    if (idex() !== e || o_id_ex_rs_data !== 32'd5) begin
      errors++;
      $display("FAIL wb_bypass got %h rs %h want %h rs 5",
               idex(), o_id_ex_rs_data, e);
    end
    i_wb_rd = 5'd0; i_wb_data = 32'd99;
    issue(rtype(5'd0, 5'd1, 5'd7, 6'h20), 32'h10);
    sb.push_back(ex(5'd7, 32'h3820, 5'b00001));
    tick();
    i_wb_we = 1'b0;
    e = sb.pop_front();
    checks++;
    if (idex() !== e || o_id_ex_rs_data !== 32'd0 ||
        o_id_ex_rt_data !== 32'd5) begin
      errors++;
      $display("FAIL r0_read got %h rs %h rt %h want %h 0 5",
               idex(), o_id_ex_rs_data, o_id_ex_rt_data, e);
    end
  endtask

  task automatic test_load_use();
    issue(itype(6'h23, 5'd0, 5'd2, 16'd0), 32'h14);
    sb.push_back(ex(5'd2, 32'd0, 5'b11011));
    tick();
    e = sb.pop_front();
    checks++;
    if (idex() !== e) begin
      errors++;
      $display("FAIL lw_idex got %h want %h", idex(), e);
    end
    issue(rtype(5'd2, 5'd2, 5'd3, 6'h20), 32'h18);
    #1;
    checks++;
    if (fc() !== 5'b00000) begin
      errors++;
      $display("FAIL lu_stall got %b want 00000", fc());
    end
    sb.push_back(42'd0);
    tick();
    e = sb.pop_front();
    checks++;
    if (idex() !== e) begin
      errors++;
      $display("FAIL lu_bubble got %h want %h", idex(), e);
    end
    #1;
    checks++;
    if (fc() !== 5'b11000) begin
      errors++;
      $display("FAIL lu_release got %b want 11000", fc());
    end
    sb.push_back(ex(5'd3, 32'h1820, 5'b00001));
    tick();
    e = sb.pop_front();
    checks++;
    if (idex() !== e) begin
      errors++;
      $display("FAIL lu_add got %h want %h", idex(), e);
    end
  endtask

  task automatic test_branch();
    issue(itype(6'h04, 5'd1, 5'd1, 16'd3), 32'h14);
    #1;
    checks++;
    if (fc() !== 5'b11101 || o_brq_addr !== 32'h20) begin
      errors++;
      $display("FAIL beq_taken got %b %h want 11101 20",
               fc(), o_brq_addr);
    end
    sb.push_back(ex(5'd1, 32'd3, 5'b00000));
    tick();
    e = sb.pop_front();
    checks++;
    if (idex() !== e) begin
      errors++;
      $display("FAIL beq_idex got %h want %h", idex(), e);
    end
    issue(itype(6'h05, 5'd1, 5'd1, 16'd3), 32'h18);
    #1;
    checks++;
    if (fc() !== 5'b11000) begin
      errors++;
      $display("FAIL bne_eq got %b want 11000", fc());
    end
    sb.push_back(ex(5'd1, 32'd3, 5'b00000));
    tick();
    void'(sb.pop_front());
    issue(itype(6'h05, 5'd1, 5'd0, 16'hFFFF), 32'h20);
    #1;
    checks++;
    if (fc() !== 5'b11101 || o_brq_addr !== 32'h1C) begin
      errors++;
      $display("FAIL bne_back got %b %h want 11101 1c",
               fc(), o_brq_addr);
    end
    sb.push_back(ex(5'd0, 32'hFFFF_FFFF, 5'b00000));
    tick();
    e = sb.pop_front();
    checks++;
    if (idex() !== e) begin
      errors++;
      $display("FAIL bne_idex got %h want %h", idex(), e);
    end
    issue(itype(6'h08, 5'd0, 5'd8, 16'd1), 32'h24);
    sb.push_back(ex(5'd8, 32'd1, 5'b10001));
    tick();
    void'(sb.pop_front());
    issue(itype(6'h04, 5'd8, 5'd0, 16'd1), 32'h28);
    #1;
    checks++;
    if (fc() !== 5'b00000) begin
      errors++;
      $display("FAIL br_idex_stall got %b want 00000", fc());
    end
    sb.push_back(42'd0);
    tick();
    e = sb.pop_front();
    checks++;
    if (idex() !== e || o_brq_addr !== 32'h2C) begin
      errors++;
      $display("FAIL br_after_stall got %h %h want %h 2c",
               idex(), o_brq_addr, e);
    end
    sb.push_back(ex(5'd0, 32'd1, 5'b00000));
    tick();
    void'(sb.pop_front());
  endtask

  task automatic test_jump();
    issue({6'h02, 26'h40}, 32'h1000_0008);
    #1;
    checks++;
    if (fc() !== 5'b11011 || o_jmp_addr !== 32'h1000_0100) begin
      errors++;
      $display("FAIL j_target got %b %h want 11011 10000100",
               fc(), o_jmp_addr);
    end
    sb.push_back(ex(5'd0, 32'h40, 5'b00000));
    tick();
    e = sb.pop_front();
    checks++;
    if (idex() !== e) begin
      errors++;
      $display("FAIL j_idex got %h want %h", idex(), e);
    end
    i_wb_we = 1'b1; i_wb_rd = 5'd31; i_wb_data = 32'h80;
    issue(32'h0, 32'h1000_000C);
    tick();
    i_wb_we = 1'b0;
    issue(rtype(5'd31, 5'd0, 5'd0, 6'h08), 32'h100);
    #1;
    checks++;
    if (fc() !== 5'b11011 || o_jmp_addr !== 32'h80) begin
      errors++;
      $display("FAIL jr_target got %b %h want 11011 80",
               fc(), o_jmp_addr);
    end
    sb.push_back(ex(5'd0, 32'd8, 5'b00000));
    tick();
    e = sb.pop_front();
    checks++;
    if (idex() !== e) begin
      errors++;
      $display("FAIL jr_idex got %h want %h", idex(), e);
    end
  endtask

  task automatic test_fwd();
    i_wb_we = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'd7;
    issue(32'h0, 32'h3C);
    tick();
    i_wb_we = 1'b0;
    i_ex_mem_reg_write = 1'b1;
    i_ex_mem_rd = 5'd4;
    i_ex_mem_data = 32'd7;
    issue(itype(6'h04, 5'd4, 5'd5, 16'd2), 32'h40);
    #1;
`ifdef ID_BRANCH_FWD_EN
    checks++;
    if (fc() !== 5'b11101 || o_brq_addr !== 32'h48) begin
      errors++;
      $display("FAIL fwd_taken got %b %h want 11101 48",
               fc(), o_brq_addr);
    end
    sb.push_back(ex(5'd5, 32'd2, 5'b00000));
    tick();
`else
    checks++;
    if (fc() !== 5'b00000) begin
      errors++;
      $display("FAIL nofwd_stall got %b want 00000", fc());
    end
    sb.push_back(42'd0);
    tick();
    e = sb.pop_front();
    checks++;
    if (idex() !== e) begin
      errors++;
      $display("FAIL nofwd_bubble got %h want %h", idex(), e);
    end
    i_ex_mem_reg_write = 1'b0;
    i_wb_we = 1'b1; i_wb_rd = 5'd4; i_wb_data = 32'd7;
    #1;
    checks++;
    if (fc() !== 5'b11101 || o_brq_addr !== 32'h48) begin
      errors++;
      $display("FAIL nofwd_taken got %b %h want 11101 48",
               fc(), o_brq_addr);
    end
    sb.push_back(ex(5'd5, 32'd2, 5'b00000));
    tick();
    i_wb_we = 1'b0;
`endif
    i_ex_mem_reg_write = 1'b0;
    e = sb.pop_front();
    checks++;
    if (idex() !== e) begin
      errors++;
      $display("FAIL fwd_idex got %h want %h", idex(), e);
    end
  endtask

  task automatic test_undef();
    issue({6'h3F, 5'd1, 5'd2, 16'h0010}, 32'h50);
    #1;
    checks++;
    if (fc() !== 5'b11000) begin
      errors++;
      $display("FAIL undef_ctl got %b want 11000", fc());
    end
    sb.push_back(ex(5'd2, 32'h10, 5'b00000));
    tick();
    e = sb.pop_front();
    checks++;
    if (idex() !== e) begin
      errors++;
      $display("FAIL undef_idex got %h want %h", idex(), e);
    end
  endtask

  task automatic test_reset_mid_stall();
    issue(itype(6'h23, 5'd0, 5'd2, 16'd4), 32'h60);
    tick();
    issue(rtype(5'd2, 5'd2, 5'd3, 6'h20), 32'h64);
    #1;
    checks++;
    if (o_pc_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_stall_pre got %b want 0", o_pc_we);
    end
    i_rst = 1'b1;
    sb.push_back(42'd0);
    tick();
    i_rst = 1'b0;
    e = sb.pop_front();
    #1;
    checks++;
    if (idex() !== e || o_pc_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_stall_clear got %h %b want %h 1",
               idex(), o_pc_we, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks %0d", checks);
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1;
    i_if_id_pc = '0;
    i_if_id_instr = '0;
    i_wb_we = 1'b0;
    i_wb_rd = '0;
    i_wb_data = '0;
    i_ex_mem_reg_write = 1'b0;
    i_ex_mem_mem_read = 1'b0;
    i_ex_mem_rd = '0;
    i_ex_mem_data = '0;
    test_reset();
    test_regfile();
    test_load_use();
    test_branch();
    test_jump();
    test_fwd();
    test_undef();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
